iter_shift_ctrl: RTL and testbench

ITER_SHIFT_CTRL -- requirements
Module: iter_shift_ctrl

---
 rtl/iter_shift_ctrl.sv | 128 ++++++++++++
 tb/tb_iter_shift_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/iter_shift_ctrl.sv
// Iterative SLL/SRL/SRA unit: shifts one bit per SHIFT cycle, with a one-cycle done pulse.
// Optional macro SHIFT_BY4_EN: shift by 4 per cycle while at least 4 positions remain.
module iter_shift_ctrl #(
  parameter int XLEN = 32,
  parameter int SW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand,
  input  logic [SW-1:0]   shamt,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ALT = 2'b11
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SW-1:0]   count_q, count_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            step_four;
  logic [SW-1:0]   step_amt;
  logic [XLEN-1:0] work_shifted;

`ifdef SHIFT_BY4_EN
  assign step_four = (count_q >= SW'(4));
`else
  assign step_four = 1'b0;
`endif

  assign step_amt = step_four ? SW'(4) : SW'(1);

  // Right shifts fill with the sign bit only for SRA; op 11 behaves as SLL.
  function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] v,
                                                 input op_t o,
                                                 input logic four);
    logic fill;
    fill = (o == OP_SRA) ? v[XLEN-1] : 1'b0;
    case (o)
      OP_SRL, OP_SRA: return four ? {{4{fill}}, v[XLEN-1:4]} : {fill, v[XLEN-1:1]};
      default:        return four ? {v[XLEN-5:0], 4'b0000} : {v[XLEN-2:0], 1'b0};
    endcase
  endfunction

  assign work_shifted = shift_step(work_q, op_q, step_four);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    count_d  = count_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d    = op_t'(op);
          work_d  = operand;
          count_d = shamt;
          if (shamt == '0) begin
            state_d  = DONE;
            result_d = operand;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          work_d  = work_shifted;
          count_d = count_q - step_amt;
          // result is only published on the final step, never mid-shift
          if (count_q == step_amt) begin
            state_d  = DONE;
            result_d = work_shifted;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-low
  // and clears every register so outputs drop to zero without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_SLL;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Directed bench for iter_shift_ctrl: latency, shift results, start-while-busy, kill and async reset.
module tb_iter_shift_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  iter_shift_ctrl #(.XLEN(32), .SW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .kill    (kill),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int exp_latency(input int n);
`ifdef SHIFT_BY4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Launch one op, then count cycles after the accept edge until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                        input logic [31:0] exp_res, input string tag);
    int lat;
    @(negedge clk);
    op = o; operand = a; shamt = s; start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = j;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_latency(int'(s))));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {30'b0, busy, done}, 32'd0);
    check({tag, "_res_hold"}, result, exp_res);
  endtask

  initial begin
    int n_done;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; operand = '0; shamt = '0;
    #1;
    check("reset_outputs", {busy, done, 30'b0} | result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll_31");
    run_op(2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, "sra_4");
    run_op(2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, "srl_4");
    run_op(2'b11, 32'h0000_F00F, 5'd8,  32'h00F0_0F00, "op11_sll_8");
    run_op(2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sra_0");
    run_op(2'b10, 32'h7000_0000, 5'd3,  32'h0E00_0000, "sra_pos_3");
    run_op(2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, "sra_31");
    run_op(2'b01, 32'hA5A5_A5A5, 5'd7,  32'h014B_4B4B, "srl_7");

    // start held high every cycle while busy with changing operands: only the first runs
    @(negedge clk);
    op = 2'b00; operand = 32'h0000_0001; shamt = 5'd5; start = 1'b1;
    n_done = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) n_done++;
      start   = busy;
      operand = 32'h1111_1111 * (j + 2);
      shamt   = 5'(j + 1);
    end
    start = 1'b0;
    check("busy_start_done_count", 32'(n_done), 32'd1);
    check("busy_start_result", result, 32'h0000_0020);

    // kill sampled at accept edge k+3 of a shamt=10 op
    @(negedge clk);
    op = 2'b00; operand = 32'h0000_FFFF; shamt = 5'd10; start = 1'b1;
    @(posedge clk);
    n_done = 0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) n_done++;
      if (j == 3) kill = 1'b1;
    end
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_low", {31'b0, busy}, 32'd0);
    check("kill_result_kept", result, 32'h0000_0020);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("kill_no_done", 32'(n_done), 32'd0);
    run_op(2'b01, 32'h0000_00F0, 5'd4, 32'h0000_000F, "after_kill");

    // kill beats start in IDLE
    @(negedge clk);
    op = 2'b00; operand = 32'h1234_5678; shamt = 5'd2; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_over_start_idle", {30'b0, busy, done}, 32'd0);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    op = 2'b00; operand = 32'h0000_0003; shamt = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy_done", {30'b0, busy, done}, 32'd0);
    check("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
